gshare_btb_predictor: RTL and testbench
=======================================

GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

Interface
REQ-001 SHALL have parameter GHR_W, default 8, meaning global history length; the PHT has 2**GHR_W entries.
REQ-002 SHALL have parameter BTB_IDX_W, default 4, meaning the BTB has 2**BTB_IDX_W direct-mapped entries.
REQ-003 SHALL have parameter XLEN, default 32, meaning address width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have these fetch-side ports:
- tahmin_ps_gecerli_i, input, 1: lookup request.
- tahmin_ps_i, input, XLEN: fetch PC.
REQ-007 SHALL have these prediction output ports:
- ongorulen_ps_gecerli_o, output, 1: predict taken.
- ongorulen_ps_o, output, XLEN: predicted target.
- ongoru_gecmis_o, output, GHR_W: history snapshot used for the lookup.
REQ-008 SHALL have these execute-side ports:
- yurut_ps_gecerli_i, input, 1: a resolved branch is presented.
- yurut_ps_i, input, XLEN: branch PC.
- yurut_gecmis_i, input, GHR_W: snapshot returned with the branch.
- yurut_atladi_i, input, 1: actual outcome, taken.
- yurut_hedef_i, input, XLEN: actual target.
- yanlis_tahmin_i, input, 1: the branch was mispredicted.
REQ-009 SHALL have these redirect output ports:
- dogru_ps_gecerli_o, output, 1: redirect fetch.
- dogru_ps_o, output, XLEN: correct PC.

Function
REQ-010 Lookup SHALL complete with 1-cycle latency; request in cycle N, all ongorulen_* outputs are registered and valid in N+1 for exactly one cycle.
REQ-011 PHT index SHALL be tahmin_ps_i[GHR_W:1] XOR ghr_spec.
REQ-012 BTB index SHALL be tahmin_ps_i[BTB_IDX_W:1]; the tag is tahmin_ps_i[XLEN-1:BTB_IDX_W+1].
REQ-013 ongorulen_ps_gecerli_o SHALL be 1 only on a BTB valid+tag hit with PHT counter >= 2; ongorulen_ps_o SHALL then be the BTB target, otherwise 0.
REQ-014 ongoru_gecmis_o SHALL equal the ghr_spec value used for the lookup.
REQ-015 On a BTB hit, ghr_spec SHALL shift left and insert the predicted direction; on a BTB miss, ghr_spec SHALL be unchanged.
REQ-016 On yurut_ps_gecerli_i, the PHT entry at yurut_ps_i[GHR_W:1] XOR yurut_gecmis_i SHALL count 2-bit saturating: up if taken, down if not; it SHALL hold at 3 and at 0.
REQ-017 On yurut_ps_gecerli_i with yurut_atladi_i=1, the BTB entry SHALL be written with valid, tag and yurut_hedef_i, overwriting any existing entry.
REQ-018 On yurut_ps_gecerli_i with yanlis_tahmin_i=1, ghr_spec SHALL be set to {yurut_gecmis_i[GHR_W-2:0], yurut_atladi_i}, overriding any same-cycle speculative shift.
REQ-019 On a mispredict, dogru_ps_gecerli_o SHALL pulse 1 cycle later for 1 cycle, with dogru_ps_o = yurut_hedef_i if taken, else yurut_ps_i+4.
REQ-020 When a lookup and an update occur in the same cycle, the lookup SHALL see the pre-update PHT/BTB contents (read-before-write), including when both hit the same index.
REQ-021 yanlis_tahmin_i SHALL be ignored when yurut_ps_gecerli_i=0.

Reset
REQ-022 While rst_i=1, and immediately on its assertion, the block SHALL hold the following state:
- all PHT counters = 1 (weakly not-taken);
- BTB valid bits = 0;
- ghr_spec = 0;
- all outputs = 0.
REQ-023 A lookup or update in flight when rst_i asserts SHALL be discarded; no output pulse SHALL follow reset release.

Configuration
REQ-024 With GSHARE_PERF_CNT_EN defined, the block SHALL add two 32-bit outputs, dal_sayac_o (resolved branches) and yanlis_sayac_o (mispredicts), each incrementing per yurut_ps_gecerli_i event, wrapping at 2**32 and reset to 0.
REQ-025 Without GSHARE_PERF_CNT_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package gshare_pkg SHALL hold:
- counter encodings GT=0, ZT=1, ZA=2, GA=3;
- default GHR_W, BTB_IDX_W and XLEN;
- the ctr_t typedef.
REQ-027 The BTB SHALL be the sub-module gshare_btb, holding the valid/tag/target arrays with one read port and one write port; the PHT and GHR SHALL stay in the top module.

Verification
REQ-028 Reset, then look up PC 0x100 -> next cycle ongorulen_ps_gecerli_o=0, ongorulen_ps_o=0, ongoru_gecmis_o=0.
REQ-029 Resolve PC 0x100 taken, target 0x200, gecmis=0, twice; then look up 0x100 with ghr_spec=0 -> predict taken to 0x200.
REQ-030 Present a taken branch four times at the same index -> counter saturates at 3; one not-taken -> 2, still predicts taken.
REQ-031 GHR_W=8, yurut_gecmis_i=0x5A, taken, yanlis_tahmin_i=1 -> next cycle ghr_spec=0xB5, dogru_ps_gecerli_o=1, dogru_ps_o=yurut_hedef_i.
REQ-032 Not-taken mispredict at 0x300 -> dogru_ps_o=0x304; a same-cycle lookup hit has its speculative shift overridden by the recovery.
REQ-033 Assert rst_i asynchronously mid-update -> outputs 0 at once, BTB cleared, and no dogru pulse after reset release.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare/BTB branch predictor: 2-bit counter
// encoding, default geometry and the saturating counter update helper.
package gshare_pkg;

    localparam int DEF_GHR_W     = 8;
    localparam int DEF_BTB_IDX_W = 4;
    localparam int DEF_XLEN      = 32;

    typedef enum logic [1:0] {
        GT = 2'd0,
        ZT = 2'd1,
        ZA = 2'd2,
        GA = 2'd3
    } ctr_t;

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        case (cur)
            GT:      nxt = taken ? ZT : GT;
            ZT:      nxt = taken ? ZA : GT;
            ZA:      nxt = taken ? GA : ZT;
            GA:      nxt = taken ? GA : ZA;
            default: nxt = ZT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_btb.sv
// Direct-mapped branch target buffer: valid/tag/target arrays with one
// combinational read port and one synchronous write port.
module gshare_btb
    import gshare_pkg::*;
#(
    parameter int IDX_W = DEF_BTB_IDX_W,
    parameter int XLEN  = DEF_XLEN,
    parameter int TAG_W = DEF_XLEN - DEF_BTB_IDX_W - 1
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [XLEN-1:0]  rd_target_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [XLEN-1:0]  wr_target_i
);

    localparam int N = 2**IDX_W;

    logic             valid_q  [N];
    logic             valid_d  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [TAG_W-1:0] tag_d    [N];
    logic [XLEN-1:0]  target_q [N];
    logic [XLEN-1:0]  target_d [N];

    // Reads see the stored contents, so a same-cycle write is not visible yet.
    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];

    // Next-state for the entry being written.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i]  = 1'b1;
            tag_d[wr_idx_i]    = wr_tag_i;
            target_d[wr_idx_i] = wr_target_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Only the valid bits need reset; tag/target are qualified by them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target storage.
    always_ff @(posedge clk_i) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and GHR recovery.
// Optional GSHARE_PERF_CNT_EN adds resolved-branch and mispredict counters.
module gshare_btb_predictor
    import gshare_pkg::*;
#(
    parameter int GHR_W     = DEF_GHR_W,
    parameter int BTB_IDX_W = DEF_BTB_IDX_W,
    parameter int XLEN      = DEF_XLEN
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tahmin_ps_gecerli_i,
    input  logic [XLEN-1:0]  tahmin_ps_i,
    output logic             ongorulen_ps_gecerli_o,
    output logic [XLEN-1:0]  ongorulen_ps_o,
    output logic [GHR_W-1:0] ongoru_gecmis_o,
    input  logic             yurut_ps_gecerli_i,
    input  logic [XLEN-1:0]  yurut_ps_i,
    input  logic [GHR_W-1:0] yurut_gecmis_i,
    input  logic             yurut_atladi_i,
    input  logic [XLEN-1:0]  yurut_hedef_i,
    input  logic             yanlis_tahmin_i,
    output logic             dogru_ps_gecerli_o,
    output logic [XLEN-1:0]  dogru_ps_o
`ifdef GSHARE_PERF_CNT_EN
   ,output logic [31:0]      dal_sayac_o,
    output logic [31:0]      yanlis_sayac_o
`else
`endif
);

    localparam int              PHT_N   = 2**GHR_W;
    localparam int              TAG_W   = XLEN - BTB_IDX_W - 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    ctr_t             pht_q [PHT_N];
    ctr_t             pht_d [PHT_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;

    logic             pred_vld_q, pred_vld_d;
    logic [XLEN-1:0]  pred_ps_q, pred_ps_d;
    logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;
    logic             dogru_vld_q, dogru_vld_d;
    logic [XLEN-1:0]  dogru_ps_q, dogru_ps_d;

    logic [GHR_W-1:0] lk_pht_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_hit_s;
    logic             lk_taken_s;
    logic [GHR_W-1:0] up_pht_idx_s;
    logic             mispredict_s;
    logic             btb_rd_valid_s;
    logic [TAG_W-1:0] btb_rd_tag_s;
    logic [XLEN-1:0]  btb_rd_target_s;
    logic             tahmin_lsb_unused_s;

    assign tahmin_lsb_unused_s = tahmin_ps_i[0];

    gshare_btb #(
        .IDX_W (BTB_IDX_W),
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (tahmin_ps_i[BTB_IDX_W:1]),
        .rd_valid_o  (btb_rd_valid_s),
        .rd_tag_o    (btb_rd_tag_s),
        .rd_target_o (btb_rd_target_s),
        .wr_en_i     (yurut_ps_gecerli_i & yurut_atladi_i),
        .wr_idx_i    (yurut_ps_i[BTB_IDX_W:1]),
        .wr_tag_i    (yurut_ps_i[XLEN-1:BTB_IDX_W+1]),
        .wr_target_i (yurut_hedef_i)
    );

    // Lookup against pre-update PHT/BTB state and registered prediction.
    always_comb begin
        lk_pht_idx_s = tahmin_ps_i[GHR_W:1] ^ ghr_q;
        lk_tag_s     = tahmin_ps_i[XLEN-1:BTB_IDX_W+1];
        lk_hit_s     = tahmin_ps_gecerli_i & btb_rd_valid_s & (btb_rd_tag_s == lk_tag_s);
        lk_taken_s   = (pht_q[lk_pht_idx_s] >= ZA);
        pred_vld_d   = 1'b0;
        pred_ps_d    = '0;
        pred_ghr_d   = '0;
        if (tahmin_ps_gecerli_i) begin
            pred_vld_d = lk_hit_s & lk_taken_s;
            pred_ps_d  = (lk_hit_s & lk_taken_s) ? btb_rd_target_s : '0;
            pred_ghr_d = ghr_q;
        end else begin
            pred_vld_d = 1'b0;
        end
    end

    // Resolution: counter training, history recovery and fetch redirect.
    always_comb begin
        up_pht_idx_s = yurut_ps_i[GHR_W:1] ^ yurut_gecmis_i;
        mispredict_s = yurut_ps_gecerli_i & yanlis_tahmin_i;
        pht_d        = pht_q;
        if (yurut_ps_gecerli_i) begin
            pht_d[up_pht_idx_s] = ctr_next(pht_q[up_pht_idx_s], yurut_atladi_i);
        end else begin
            pht_d = pht_q;
        end

        ghr_d = ghr_q;
        if (mispredict_s) begin
            ghr_d = {yurut_gecmis_i[GHR_W-2:0], yurut_atladi_i};
        end else if (lk_hit_s) begin
            ghr_d = {ghr_q[GHR_W-2:0], lk_taken_s};
        end else begin
            ghr_d = ghr_q;
        end

        dogru_vld_d = mispredict_s;
        dogru_ps_d  = '0;
        if (mispredict_s) begin
            dogru_ps_d = yurut_atladi_i ? yurut_hedef_i : (yurut_ps_i + PC_STEP);
        end else begin
            dogru_ps_d = '0;
        end
    end

    // Predictor state and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= ZT;
            end
            ghr_q       <= '0;
            pred_vld_q  <= 1'b0;
            pred_ps_q   <= '0;
            pred_ghr_q  <= '0;
            dogru_vld_q <= 1'b0;
            dogru_ps_q  <= '0;
        end else begin
            pht_q       <= pht_d;
            ghr_q       <= ghr_d;
            pred_vld_q  <= pred_vld_d;
            pred_ps_q   <= pred_ps_d;
            pred_ghr_q  <= pred_ghr_d;
            dogru_vld_q <= dogru_vld_d;
            dogru_ps_q  <= dogru_ps_d;
        end
    end

    assign ongorulen_ps_gecerli_o = pred_vld_q;
    assign ongorulen_ps_o         = pred_ps_q;
    assign ongoru_gecmis_o        = pred_ghr_q;
    assign dogru_ps_gecerli_o     = dogru_vld_q;
    assign dogru_ps_o             = dogru_ps_q;

`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] dal_sayac_q, dal_sayac_d;
    logic [31:0] yanlis_sayac_q, yanlis_sayac_d;

    // Free-running wrap-around event counters.
    always_comb begin
        dal_sayac_d    = dal_sayac_q;
        yanlis_sayac_d = yanlis_sayac_q;
        if (yurut_ps_gecerli_i) begin
            dal_sayac_d    = dal_sayac_q + 32'd1;
            yanlis_sayac_d = yanlis_sayac_q + {31'd0, yanlis_tahmin_i};
        end else begin
            dal_sayac_d = dal_sayac_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dal_sayac_q    <= 32'd0;
            yanlis_sayac_q <= 32'd0;
        end else begin
            dal_sayac_q    <= dal_sayac_d;
            yanlis_sayac_q <= yanlis_sayac_d;
        end
    end

    assign dal_sayac_o    = dal_sayac_q;
    assign yanlis_sayac_o = yanlis_sayac_q;
`else
`endif

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed vector table,
// asynchronous reset sequence, then random traffic against a reference model.
module tb_gshare_btb_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tahmin_ps_gecerli_i = 1'b0;
    logic [31:0] tahmin_ps_i = 32'd0;
    logic        ongorulen_ps_gecerli_o;
    logic [31:0] ongorulen_ps_o;
    logic [7:0]  ongoru_gecmis_o;
    logic        yurut_ps_gecerli_i = 1'b0;
    logic [31:0] yurut_ps_i = 32'd0;
    logic [7:0]  yurut_gecmis_i = 8'd0;
    logic        yurut_atladi_i = 1'b0;
    logic [31:0] yurut_hedef_i = 32'd0;
    logic        yanlis_tahmin_i = 1'b0;
    logic        dogru_ps_gecerli_o;
    logic [31:0] dogru_ps_o;

    gshare_btb_predictor #(.GHR_W(8), .BTB_IDX_W(4), .XLEN(32)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .tahmin_ps_gecerli_i    (tahmin_ps_gecerli_i),
        .tahmin_ps_i            (tahmin_ps_i),
        .ongorulen_ps_gecerli_o (ongorulen_ps_gecerli_o),
        .ongorulen_ps_o         (ongorulen_ps_o),
        .ongoru_gecmis_o        (ongoru_gecmis_o),
        .yurut_ps_gecerli_i     (yurut_ps_gecerli_i),
        .yurut_ps_i             (yurut_ps_i),
        .yurut_gecmis_i         (yurut_gecmis_i),
        .yurut_atladi_i         (yurut_atladi_i),
        .yurut_hedef_i          (yurut_hedef_i),
        .yanlis_tahmin_i        (yanlis_tahmin_i),
        .dogru_ps_gecerli_o     (dogru_ps_gecerli_o),
        .dogru_ps_o             (dogru_ps_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        lk;
        logic [31:0] lk_pc;
        logic        up;
        logic [31:0] up_pc;
        logic [7:0]  up_g;
        logic        up_t;
        logic [31:0] up_tgt;
        logic        up_mis;
        logic        e_v;
        logic [31:0] e_t;
        logic [7:0]  e_g;
        logic        e_dv;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[15];

    // Reference model: plain integer arrays, indices computed arithmetically.
    int          m_pht[256];
    bit          m_bv[16];
    logic [31:0] m_tag[16];
    logic [31:0] m_tgt[16];
    int          m_ghr;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
        m_ghr = 0;
    endtask

    task automatic model_step(output logic ev, output logic [31:0] et, output logic [7:0] eg,
                              output logic edv, output logic [31:0] ed);
        int pi, bi, ui, ng;
        bit hit, tk;
        ev = 1'b0; et = 32'd0; eg = 8'd0; edv = 1'b0; ed = 32'd0;
        hit = 1'b0; tk = 1'b0; ng = m_ghr;
        if (tahmin_ps_gecerli_i) begin
            pi  = ((tahmin_ps_i >> 1) % 256) ^ m_ghr;
            bi  = (tahmin_ps_i >> 1) % 16;
            hit = m_bv[bi] && (m_tag[bi] == (tahmin_ps_i >> 5));
            tk  = hit && (m_pht[pi] >= 2);
            ev  = tk;
            et  = tk ? m_tgt[bi] : 32'd0;
            eg  = m_ghr[7:0];
            if (hit) ng = (m_ghr * 2 + int'(tk)) % 256;
        end
        if (yurut_ps_gecerli_i) begin
            ui = ((yurut_ps_i >> 1) % 256) ^ int'(yurut_gecmis_i);
            if (yurut_atladi_i) begin
                if (m_pht[ui] < 3) m_pht[ui]++;
                bi = (yurut_ps_i >> 1) % 16;
                m_bv[bi]  = 1'b1;
                m_tag[bi] = yurut_ps_i >> 5;
                m_tgt[bi] = yurut_hedef_i;
            end else begin
                if (m_pht[ui] > 0) m_pht[ui]--;
            end
            if (yanlis_tahmin_i) begin
                ng  = (int'(yurut_gecmis_i) * 2 + int'(yurut_atladi_i)) % 256;
                edv = 1'b1;
                ed  = yurut_atladi_i ? yurut_hedef_i : yurut_ps_i + 32'd4;
            end
        end
        m_ghr = ng;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input logic lk, input logic [31:0] lpc, input logic up, input logic [31:0] upc,
                         input logic [7:0] ug, input logic ut, input logic [31:0] utgt, input logic um);
        tahmin_ps_gecerli_i = lk;
        tahmin_ps_i         = lpc;
        yurut_ps_gecerli_i  = up;
        yurut_ps_i          = upc;
        yurut_gecmis_i      = ug;
        yurut_atladi_i      = ut;
        yurut_hedef_i       = utgt;
        yanlis_tahmin_i     = um;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] et, input logic [7:0] eg,
                             input logic edv, input logic [31:0] ed);
        chk({tag, " pred_vld"}, {31'd0, ongorulen_ps_gecerli_o}, {31'd0, ev});
        chk({tag, " pred_ps"}, ongorulen_ps_o, et);
        chk({tag, " gecmis"}, {24'd0, ongoru_gecmis_o}, {24'd0, eg});
        chk({tag, " dogru_vld"}, {31'd0, dogru_ps_gecerli_o}, {31'd0, edv});
        chk({tag, " dogru_ps"}, dogru_ps_o, ed);
    endtask

    // One clock of model-checked traffic with the inputs already driven.
    task automatic model_cycle(input string tag);
        logic ev, edv;
        logic [31:0] et, ed;
        logic [7:0] eg;
        model_step(ev, et, eg, edv, ed);
        @(posedge clk_i);
        #1;
        check_all(tag, ev, et, eg, edv, ed);
    endtask

    initial begin
        logic ev, edv;
        logic [31:0] et, ed;
        logic [7:0] eg;

        //        lk  lk_pc        up  up_pc        g      t     tgt          mis   e_v   e_t          e_g    e_dv  e_d
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 32'h100, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 32'h100, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 8'h00, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'h01, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 32'h100, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'h100, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 32'h100, 8'h00, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'h00, 1'b1, 32'h104};
        tbl[8]  = '{1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 8'h00, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'h400, 8'h5A, 1'b1, 32'h480, 1'b1, 1'b0, 32'h0,   8'h00, 1'b1, 32'h480};
        tbl[10] = '{1'b1, 32'h700, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'hB5, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 32'h400, 1'b1, 32'h300, 8'h12, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'hB5, 1'b1, 32'h304};
        tbl[12] = '{1'b1, 32'h700, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'h24, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 32'h500, 1'b1, 32'h500, 8'h24, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0,   8'h24, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 32'h500, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b1, 32'h600, 8'h24, 1'b0, 32'h0};

        model_reset();
        #1;
        check_all("reset", 1'b0, 32'd0, 8'd0, 1'b0, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed table; the model tracks state but the table supplies expectations.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].lk, tbl[i].lk_pc, tbl[i].up, tbl[i].up_pc, tbl[i].up_g,
                  tbl[i].up_t, tbl[i].up_tgt, tbl[i].up_mis);
            model_step(ev, et, eg, edv, ed);
            @(posedge clk_i);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_t, tbl[i].e_g, tbl[i].e_dv, tbl[i].e_d);
        end

        // Asynchronous reset in the middle of a mispredict update.
        drive(1'b1, 32'h500, 1'b1, 32'h100, 8'h00, 1'b1, 32'h200, 1'b1);
        model_cycle("pre_rst");
        drive(1'b1, 32'h500, 1'b1, 32'h300, 8'h07, 1'b0, 32'h0, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 32'd0, 8'd0, 1'b0, 32'd0);
        model_reset();
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) model_cycle("post_rst_idle");
        drive(1'b1, 32'h500, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
        model_cycle("post_rst_lookup");
        chk("btb_cleared", {31'd0, ongorulen_ps_gecerli_o}, 32'd0);

        // Randomized traffic over a small PC window so hits and aliasing occur.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)),
                  32'h1000 + (32'($urandom_range(0, 31)) << 2),
                  1'($urandom_range(0, 1)),
                  32'h1000 + (32'($urandom_range(0, 31)) << 2),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)),
                  32'h2000 + (32'($urandom_range(0, 255)) << 2),
                  1'($urandom_range(0, 3) == 0));
            model_cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
